hex_display_sequencer: RTL and testbench

- Sequences updates to a bank of NUM_DIGITS 8-bit seven-segment PIO output ports.
- Takes a packed hex value from one of two requesters, arbitrated round-robin, and converts each nibble to an active-low segment pattern.
- Issues one Avalon-MM write per changed digit to the PIO slaves over a shared master interface.
- Sits between the CPU-side and hardware-side display sources and the per-digit PIO slaves.

---
 rtl/hex_display_sequencer.sv | 177 +++++++++++++++++
 tb/tb_hex_display_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_sequencer.sv
// Two-requester hex display sequencer. It arbitrates round-robin, converts each
// nibble to an active-low segment pattern and issues one Avalon-MM write per changed digit.
module hex_display_sequencer #(
   parameter int NUM_DIGITS = 4,
   parameter int ADDR_W     = 8,
   parameter int BASE_ADDR  = 0,
   parameter int STRIDE     = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req0_valid,
   output logic                    req0_ready,
   input  logic [4*NUM_DIGITS-1:0] req0_value,
   input  logic [NUM_DIGITS-1:0]   req0_dp,
   input  logic                    req0_force,
   input  logic                    req1_valid,
   output logic                    req1_ready,
   input  logic [4*NUM_DIGITS-1:0] req1_value,
   input  logic [NUM_DIGITS-1:0]   req1_dp,
   input  logic                    req1_force,
   output logic [ADDR_W-1:0]       avm_address,
   output logic                    avm_chipselect,
   output logic                    avm_write_n,
   output logic [31:0]             avm_writedata,
   input  logic                    avm_waitrequest,
   output logic                    busy,
   output logic                    done,
   output logic                    done_id
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] value_q, value_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d;
   logic                    force_q, force_d;
   logic                    doneId_q, doneId_d;
   logic                    prio_q, prio_d;
   logic [7:0]              shadowPat_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   shadowVld_q;

   logic       grant;
   logic       shadowWe;
   logic       needWrite;
   logic       lastDigit;
   logic [3:0] nibble;
   logic [7:0] pattern;

   function automatic logic [6:0] segCode(input logic [3:0] nib);
      segCode = 7'h7F;
      case (nib)
         4'h0: segCode = 7'h40;
         4'h1: segCode = 7'h79;
         4'h2: segCode = 7'h24;
         4'h3: segCode = 7'h30;
         4'h4: segCode = 7'h19;
         4'h5: segCode = 7'h12;
         4'h6: segCode = 7'h02;
         4'h7: segCode = 7'h78;
         4'h8: segCode = 7'h00;
         4'h9: segCode = 7'h10;
         4'hA: segCode = 7'h08;
         4'hB: segCode = 7'h03;
         4'hC: segCode = 7'h46;
         4'hD: segCode = 7'h21;
         4'hE: segCode = 7'h06;
         4'hF: segCode = 7'h0E;
         default: segCode = 7'h7F;
      endcase
   endfunction

   always_comb begin
      nibble    = value_q[4*int'(idx_q) +: 4];
      pattern   = {~dp_q[idx_q], segCode(nibble)};
      lastDigit = (idx_q == LAST_IDX);
      needWrite = force_q || !shadowVld_q[idx_q] || (pattern != shadowPat_q[idx_q]);
   end

   // When both requesters are valid, prio_q names the one that was not served last.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      value_d    = value_q;
      dp_d       = dp_q;
      force_d    = force_q;
      doneId_d   = doneId_q;
      prio_d     = prio_q;
      grant      = 1'b0;
      shadowWe   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (reset_n && (req0_valid || req1_valid)) begin
               grant      = (req0_valid && req1_valid) ? prio_q : req1_valid;
               req0_ready = ~grant;
               req1_ready = grant;
               value_d    = grant ? req1_value : req0_value;
               dp_d       = grant ? req1_dp : req0_dp;
               force_d    = grant ? req1_force : req0_force;
               prio_d     = ~grant;
               doneId_d   = grant;
               idx_d      = '0;
               state_d    = SCAN;
            end
         end
         SCAN: begin
            if (needWrite) begin
               state_d = WRITE;
            end else if (lastDigit) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         WRITE: begin
            if (!avm_waitrequest) begin
               shadowWe = 1'b1;
               if (lastDigit) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = SCAN;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign avm_address    = ADDR_W'(BASE_ADDR + STRIDE * int'(idx_q));
   assign avm_chipselect = (state_q == WRITE);
   assign avm_write_n    = (state_q != WRITE);
   assign avm_writedata  = (state_q == WRITE) ? {24'b0, pattern} : 32'b0;
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);
   assign done_id        = doneId_q;

   // Reset abandons any in-flight write and invalidates every shadow entry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         value_q     <= '0;
         dp_q        <= '0;
         force_q     <= 1'b0;
         doneId_q    <= 1'b0;
         prio_q      <= 1'b0;
         shadowVld_q <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadowPat_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         value_q  <= value_d;
         dp_q     <= dp_d;
         force_q  <= force_d;
         doneId_q <= doneId_d;
         prio_q   <= prio_d;
         if (shadowWe) begin
            shadowPat_q[idx_q] <= pattern;
            shadowVld_q[idx_q] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Self-checking bench for hex_display_sequencer: directed scenarios followed by randomized
// requests, checked against a digit-level shadow model and a write scoreboard.
module tb_hex_display_sequencer;

   localparam int NUM_DIGITS = 4;
   localparam int ADDR_W     = 8;
   localparam int BASE_ADDR  = 0;
   localparam int STRIDE     = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req0_valid, req0_ready, req0_force;
   logic [15:0] req0_value;
   logic [3:0]  req0_dp;
   logic        req1_valid, req1_ready, req1_force;
   logic [15:0] req1_value;
   logic [3:0]  req1_dp;
   logic [ADDR_W-1:0] avm_address;
   logic        avm_chipselect, avm_write_n, avm_waitrequest;
   logic [31:0] avm_writedata;
   logic        busy, done, done_id;

   always #5 clk = ~clk;

   hex_display_sequencer #(
      .NUM_DIGITS(NUM_DIGITS), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .STRIDE(STRIDE)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_value(req0_value),
      .req0_dp(req0_dp), .req0_force(req0_force),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_value(req1_value),
      .req1_dp(req1_dp), .req1_force(req1_force),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
      .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
      .busy(busy), .done(done), .done_id(done_id)
   );

   logic [7:0] segTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   int totalChecks = 0;
   int passCount   = 0;

   bit          pending [2];
   logic [15:0] reqVal [2];
   logic [3:0]  reqDp [2];
   bit          reqForce [2];
   logic [7:0]  shadowPat [NUM_DIGITS];
   bit          shadowVld [NUM_DIGITS];
   int          prio;
   bit          inFlight;
   int          servedId, readyCycle, expWrites, stalls, cycle, lastLatency;
   int          expAddrQ [$];
   int          expDataQ [$];
   int          grantLog [$];
   bit          prevStall, prevCompleted, randomWait, sawCs;
   logic [ADDR_W-1:0] prevAddr;
   logic [31:0] prevData;
   int          stallAddr, stallLeft, stallsSeen, writesSeen;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, observed, expected, cycle);
      end
   endtask

   task automatic resetModel();
      prio = 0;
      inFlight = 0;
      pending[0] = 0;
      pending[1] = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         shadowVld[i] = 0;
         shadowPat[i] = 8'h00;
      end
      expAddrQ.delete();
      expDataQ.delete();
      prevStall = 0;
      prevCompleted = 0;
      stallLeft = 0;
   endtask

   task automatic applyStimulus(input int id, input logic [15:0] v, input logic [3:0] dp, input bit f);
      pending[id]  = 1;
      reqVal[id]   = v;
      reqDp[id]    = dp;
      reqForce[id] = f;
   endtask

   // Digit-level model: a digit is written when forced, unknown, or its pattern changed.
   task automatic startUpdate(input int g);
      logic [7:0]  pat;
      logic [15:0] v;
      v = reqVal[g];
      expWrites = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         pat = segTable[v[4*i +: 4]];
         if (reqDp[g][i]) pat[7] = 1'b0;
         if (reqForce[g] || !shadowVld[i] || pat != shadowPat[i]) begin
            expAddrQ.push_back(BASE_ADDR + i * STRIDE);
            expDataQ.push_back(int'(pat));
            expWrites++;
            shadowPat[i] = pat;
            shadowVld[i] = 1;
         end
      end
      pending[g]  = 0;
      reqVal[g]   = 16'($urandom);
      reqDp[g]    = 4'($urandom);
      reqForce[g] = 1'($urandom);
      prio        = 1 - g;
      servedId    = g;
      readyCycle  = cycle;
      stalls      = 0;
      inFlight    = 1;
   endtask

   task automatic runCycle();
      int         eg, a, d, lat;
      logic [1:0] rdy;
      @(posedge clk);
      #1;
      if (avm_chipselect && stallLeft > 0 && 32'(avm_address) == stallAddr) begin
         avm_waitrequest = 1'b1;
         stallLeft--;
      end else begin
         avm_waitrequest = randomWait && avm_chipselect && ($urandom_range(0, 3) == 0);
      end
      req0_valid = pending[0];
      req0_value = reqVal[0];
      req0_dp    = reqDp[0];
      req0_force = reqForce[0];
      req1_valid = pending[1];
      req1_value = reqVal[1];
      req1_dp    = reqDp[1];
      req1_force = reqForce[1];
      @(negedge clk);
      cycle++;
      if (prevStall) begin
         checkOutput("stall cs", 32'(avm_chipselect), 1);
         checkOutput("stall addr", 32'(avm_address), 32'(prevAddr));
         checkOutput("stall data", avm_writedata, prevData);
      end
      if (prevCompleted) checkOutput("write gap", 32'(avm_chipselect), 0);
      if (avm_chipselect) sawCs = 1;
      rdy = {req1_ready, req0_ready};
      if (rdy != 2'b00) begin
         if (!pending[0] && !pending[1]) begin
            checkOutput("spurious ready", 32'(rdy), 0);
         end else begin
            eg = (pending[0] && pending[1]) ? prio : (pending[1] ? 1 : 0);
            checkOutput("grant", 32'(rdy), (eg == 1) ? 2 : 1);
            checkOutput("accept while busy", 32'(inFlight), 0);
            checkOutput("busy at accept", 32'(busy), 0);
            grantLog.push_back(eg);
            startUpdate(eg);
         end
      end
      if (avm_chipselect && !avm_waitrequest) begin
         checkOutput("write expected", 32'(expAddrQ.size() > 0), 1);
         if (expAddrQ.size() > 0) begin
            a = expAddrQ.pop_front();
            d = expDataQ.pop_front();
            checkOutput("write addr", 32'(avm_address), a);
            checkOutput("write data", avm_writedata, d);
         end
         checkOutput("write strobe", 32'(avm_write_n), 0);
         writesSeen++;
      end
      if (avm_chipselect && avm_waitrequest) begin
         stallsSeen++;
         if (inFlight) stalls++;
      end
      if (done) begin
         checkOutput("done expected", 32'(inFlight), 1);
         if (inFlight) begin
            lat = cycle - readyCycle;
            checkOutput("done_id", 32'(done_id), servedId);
            checkOutput("writes left", expAddrQ.size(), 0);
            checkOutput("latency", lat, 1 + NUM_DIGITS + expWrites + stalls);
            checkOutput("busy in done", 32'(busy), 1);
            lastLatency = lat;
         end
         inFlight = 0;
      end
      prevStall     = avm_chipselect && avm_waitrequest;
      prevCompleted = avm_chipselect && !avm_waitrequest;
      prevAddr      = avm_address;
      prevData      = avm_writedata;
   endtask

   task automatic runUntilQuiet(input int budget);
      int n;
      n = 0;
      while ((pending[0] || pending[1] || inFlight) && n < budget) begin
         runCycle();
         n++;
      end
      checkOutput("quiet timeout", 32'(pending[0] || pending[1] || inFlight), 0);
   endtask

   task automatic resetChecks(input string tag);
      checkOutput({tag, " cs"}, 32'(avm_chipselect), 0);
      checkOutput({tag, " write_n"}, 32'(avm_write_n), 1);
      checkOutput({tag, " addr"}, 32'(avm_address), BASE_ADDR);
      checkOutput({tag, " wdata"}, avm_writedata, 0);
      checkOutput({tag, " ready0"}, 32'(req0_ready), 0);
      checkOutput({tag, " ready1"}, 32'(req1_ready), 0);
      checkOutput({tag, " busy"}, 32'(busy), 0);
      checkOutput({tag, " done"}, 32'(done), 0);
      checkOutput({tag, " done_id"}, 32'(done_id), 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int expOrder [3];
      int n, mask;
      expOrder = '{0, 1, 0};
      reset_n = 1'b0;
      req0_valid = 0; req0_value = '0; req0_dp = '0; req0_force = 0;
      req1_valid = 0; req1_value = '0; req1_dp = '0; req1_force = 0;
      avm_waitrequest = 0;
      cycle = 0; lastLatency = 0; stallsSeen = 0; writesSeen = 0;
      stallAddr = 0; randomWait = 0; sawCs = 0;
      servedId = 0; readyCycle = 0; expWrites = 0; stalls = 0;
      prevAddr = '0; prevData = '0;
      for (int r = 0; r < 2; r++) begin
         reqVal[r] = '0; reqDp[r] = '0; reqForce[r] = 0;
      end
      resetModel();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetChecks("por");
      @(posedge clk);
      #1 reset_n = 1'b1;

      writesSeen = 0;
      applyStimulus(0, 16'h1234, 4'h0, 0);
      runUntilQuiet(100);
      checkOutput("first update writes", writesSeen, 4);
      checkOutput("first update latency", lastLatency, 9);

      writesSeen = 0;
      applyStimulus(0, 16'h1234, 4'h0, 0);
      runUntilQuiet(100);
      checkOutput("repeat writes", writesSeen, 0);
      checkOutput("repeat latency", lastLatency, 5);

      writesSeen = 0;
      applyStimulus(1, 16'h123F, 4'b0001, 0);
      runUntilQuiet(100);
      checkOutput("req1 writes", writesSeen, 1);
      checkOutput("req1 done_id", 32'(done_id), 1);

      grantLog.delete();
      applyStimulus(0, 16'h5678, 4'h0, 0);
      applyStimulus(1, 16'h9ABC, 4'h0, 0);
      n = 0;
      while (grantLog.size() < 1 && n < 50) begin
         runCycle();
         n++;
      end
      applyStimulus(0, 16'hDEF0, 4'h0, 0);
      runUntilQuiet(200);
      checkOutput("grant count", grantLog.size(), 3);
      for (int i = 0; i < 3 && i < grantLog.size(); i++) begin
         checkOutput("grant order", grantLog[i], expOrder[i]);
      end

      writesSeen = 0;
      applyStimulus(0, 16'h1234, 4'h0, 1);
      runUntilQuiet(100);
      writesSeen = 0;
      applyStimulus(0, 16'h1234, 4'h0, 1);
      runUntilQuiet(100);
      checkOutput("force writes", writesSeen, 4);

      writesSeen = 0;
      stallsSeen = 0;
      stallAddr = 16;
      stallLeft = 3;
      applyStimulus(1, 16'h1204, 4'h0, 0);
      runUntilQuiet(100);
      checkOutput("stall writes", writesSeen, 1);
      checkOutput("stall cycles", stallsSeen, 3);
      checkOutput("stall latency", lastLatency, 9);

      stallAddr = 0;
      stallLeft = 100;
      sawCs = 0;
      applyStimulus(1, 16'hABCD, 4'h0, 0);
      n = 0;
      while (!sawCs && n < 50) begin
         runCycle();
         n++;
      end
      checkOutput("write reached before reset", 32'(sawCs), 1);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      req0_valid = 0;
      req1_valid = 0;
      @(negedge clk);
      checkOutput("cs held until reset edge", 32'(avm_chipselect), 1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      avm_waitrequest = 0;
      @(negedge clk);
      resetChecks("mid-write reset");
      resetModel();

      writesSeen = 0;
      applyStimulus(0, 16'h1234, 4'h0, 0);
      runUntilQuiet(100);
      checkOutput("post-reset writes", writesSeen, 4);

      randomWait = 1;
      for (int it = 0; it < 40; it++) begin
         mask = $urandom_range(1, 3);
         for (int r = 0; r < 2; r++) begin
            if (mask[r]) begin
               applyStimulus(r, ($urandom_range(0, 2) == 0) ? 16'h1234 : 16'($urandom),
                             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                             $urandom_range(0, 5) == 0);
            end
         end
         runUntilQuiet(400);
      end

      $display("%0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

endmodule
